rtmc_reg_arb: RTL and testbench

//  Two-initiator arbiter for the shared register bus (addr/wdat/wr/rd/rdat/ack).

---
 rtl/rtmc_reg_arb.sv | 212 +++++++++++++++++++++
 tb/tb_rtmc_reg_arb.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtmc_reg_arb.sv
// -----------------------------------------------------------------------------
// rtmc_reg_arb
// Round-robin arbiter that shares one register bus between two initiators.
// Initiator 0 is the SPI command decoder and initiator 1 is the motor
// sequencer. The granted transaction is registered onto the single responder
// (the register file). A transaction that the responder never acknowledges is
// ended by a timeout, which returns all-ones data and raises an error flag.
//
// Parameters
//   ADDR_W   register address width
//   DATA_W   register data width
//   TIMEOUT  BUSY cycles to wait for r_ack_i before giving up; 0 = wait forever
//
// Ports
//   clk              clock, all logic on the rising edge
//   rst_n            asynchronous active-low reset
//   iN_addr_i        initiator N address
//   iN_wdat_i        initiator N write data
//   iN_wr_i          initiator N write request (level, held until iN_ack_o)
//   iN_rd_i          initiator N read request (level, held until iN_ack_o)
//   iN_rdat_o        initiator N read data, held until that initiator's next ack
//   iN_ack_o         initiator N one-cycle completion pulse
//   iN_err_o         initiator N timeout flag, valid with iN_ack_o
//   r_addr_o         responder address
//   r_wdat_o         responder write data
//   r_wr_o           responder write strobe (level, held until r_ack_i)
//   r_rd_o           responder read strobe (level, held until r_ack_i)
//   r_rdat_i         responder read data, sampled with r_ack_i
//   r_ack_i          responder completion pulse
// -----------------------------------------------------------------------------
module rtmc_reg_arb #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] i0_addr_i,
  input  logic [DATA_W-1:0] i0_wdat_i,
  input  logic              i0_wr_i,
  input  logic              i0_rd_i,
  output logic [DATA_W-1:0] i0_rdat_o,
  output logic              i0_ack_o,
  output logic              i0_err_o,
  input  logic [ADDR_W-1:0] i1_addr_i,
  input  logic [DATA_W-1:0] i1_wdat_i,
  input  logic              i1_wr_i,
  input  logic              i1_rd_i,
  output logic [DATA_W-1:0] i1_rdat_o,
  output logic              i1_ack_o,
  output logic              i1_err_o,
  output logic [ADDR_W-1:0] r_addr_o,
  output logic [DATA_W-1:0] r_wdat_o,
  output logic              r_wr_o,
  output logic              r_rd_o,
  input  logic [DATA_W-1:0] r_rdat_i,
  input  logic              r_ack_i
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // A zero-width counter is illegal, so TIMEOUT=0 still gets one bit.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

  logic [1:0]        state_q,  state_d;
  logic              last_q,   last_d;    // initiator granted most recently
  logic              gnt_q,    gnt_d;     // initiator owning the current cycle
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic [ADDR_W-1:0] r_addr_q, r_addr_d;
  logic [DATA_W-1:0] r_wdat_q, r_wdat_d;
  logic              r_wr_q,   r_wr_d;
  logic              r_rd_q,   r_rd_d;
  logic [DATA_W-1:0] rdat0_q,  rdat0_d;
  logic [DATA_W-1:0] rdat1_q,  rdat1_d;
  logic              ack0_q,   ack0_d;
  logic              ack1_q,   ack1_d;
  logic              err0_q,   err0_d;
  logic              err1_q,   err1_d;

  logic req0, req1, pick1, sel_wr, sel_rd, expired;

  assign req0 = i0_wr_i | i0_rd_i;
  assign req1 = i1_wr_i | i1_rd_i;

  // Initiator 1 wins when it asks alone, or on a tie when initiator 0 was
  // granted last.
  assign pick1  = req1 & (~req0 | ~last_q);
  assign sel_wr = pick1 ? i1_wr_i : i0_wr_i;
  assign sel_rd = pick1 ? i1_rd_i : i0_rd_i;

  assign expired = (TIMEOUT != 0) && (cnt_q == CNT_LIMIT);

  always_comb begin
    // NOTE: every signal assigned below gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_d  = state_q;
    last_d   = last_q;
    gnt_d    = gnt_q;
    cnt_d    = cnt_q;
    r_addr_d = r_addr_q;
    r_wdat_d = r_wdat_q;
    r_wr_d   = r_wr_q;
    r_rd_d   = r_rd_q;
    rdat0_d  = rdat0_q;
    rdat1_d  = rdat1_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    err0_d   = 1'b0;
    err1_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          gnt_d    = pick1;
          last_d   = pick1;
          r_addr_d = pick1 ? i1_addr_i : i0_addr_i;
          r_wdat_d = pick1 ? i1_wdat_i : i0_wdat_i;
          r_wr_d   = sel_wr;
          r_rd_d   = sel_rd & ~sel_wr;  // write takes precedence over read
          cnt_d    = '0;
          state_d  = ST_BUSY;
        end
      end

      ST_BUSY: begin
        cnt_d = cnt_q + CNT_W'(1);
        // An ack in the expiry cycle is checked first so it completes cleanly.
        if (r_ack_i) begin
          r_wr_d  = 1'b0;
          r_rd_d  = 1'b0;
          state_d = ST_DONE;
          if (gnt_q) begin
            rdat1_d = r_rdat_i;
            ack1_d  = 1'b1;
          end else begin
            rdat0_d = r_rdat_i;
            ack0_d  = 1'b1;
          end
        end else if (expired) begin
          r_wr_d  = 1'b0;
          r_rd_d  = 1'b0;
          state_d = ST_DONE;
          if (gnt_q) begin
            rdat1_d = '1;
            ack1_d  = 1'b1;
            err1_d  = 1'b1;
          end else begin
            rdat0_d = '1;
            ack0_d  = 1'b1;
            err0_d  = 1'b1;
          end
        end
      end

      // The ack pulse is visible for this one cycle; requests are not sampled.
      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      last_q   <= 1'b1;       // initiator 0 wins the first tie
      gnt_q    <= 1'b0;
      cnt_q    <= '0;
      r_addr_q <= '0;
      r_wdat_q <= '0;
      r_wr_q   <= 1'b0;
      r_rd_q   <= 1'b0;
      rdat0_q  <= '0;
      rdat1_q  <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      gnt_q    <= gnt_d;
      cnt_q    <= cnt_d;
      r_addr_q <= r_addr_d;
      r_wdat_q <= r_wdat_d;
      r_wr_q   <= r_wr_d;
      r_rd_q   <= r_rd_d;
      rdat0_q  <= rdat0_d;
      rdat1_q  <= rdat1_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
    end
  end

  assign r_addr_o  = r_addr_q;
  assign r_wdat_o  = r_wdat_q;
  assign r_wr_o    = r_wr_q;
  assign r_rd_o    = r_rd_q;
  assign i0_rdat_o = rdat0_q;
  assign i0_ack_o  = ack0_q;
  assign i0_err_o  = err0_q;
  assign i1_rdat_o = rdat1_q;
  assign i1_ack_o  = ack1_q;
  assign i1_err_o  = err1_q;

endmodule

// File: tb/tb_rtmc_reg_arb.sv
// -----------------------------------------------------------------------------
// tb_rtmc_reg_arb
// Directed bench for rtmc_reg_arb with default parameters (8/16/15).
// Inputs are driven and outputs sampled on the falling clock edge; the DUT
// acts on the rising edge. A background responder acknowledges after a
// programmable number of strobe cycles (negative = never).
// -----------------------------------------------------------------------------
module tb_rtmc_reg_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  i0_addr = '0, i1_addr = '0;
  logic [15:0] i0_wdat = '0, i1_wdat = '0;
  logic        i0_wr = 1'b0, i0_rd = 1'b0, i1_wr = 1'b0, i1_rd = 1'b0;
  logic [15:0] i0_rdat, i1_rdat;
  logic        i0_ack, i0_err, i1_ack, i1_err;
  logic [7:0]  r_addr;
  logic [15:0] r_wdat;
  logic        r_wr, r_rd;
  logic [15:0] r_rdat = '0;
  logic        r_ack = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  rtmc_reg_arb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i0_addr_i (i0_addr),
    .i0_wdat_i (i0_wdat),
    .i0_wr_i   (i0_wr),
    .i0_rd_i   (i0_rd),
    .i0_rdat_o (i0_rdat),
    .i0_ack_o  (i0_ack),
    .i0_err_o  (i0_err),
    .i1_addr_i (i1_addr),
    .i1_wdat_i (i1_wdat),
    .i1_wr_i   (i1_wr),
    .i1_rd_i   (i1_rd),
    .i1_rdat_o (i1_rdat),
    .i1_ack_o  (i1_ack),
    .i1_err_o  (i1_err),
    .r_addr_o  (r_addr),
    .r_wdat_o  (r_wdat),
    .r_wr_o    (r_wr),
    .r_rd_o    (r_rd),
    .r_rdat_i  (r_rdat),
    .r_ack_i   (r_ack)
  );

  always #5 clk = ~clk;

  // Responder model: ack in strobe cycle index resp_delay (0 = first cycle).
  int          resp_delay = 0;
  logic [15:0] resp_data  = '0;
  logic        spurious   = 1'b0;
  int          strobe_cnt = 0;

  always @(negedge clk) begin
    r_ack = 1'b0;
    if (r_wr || r_rd) begin
      if (resp_delay >= 0 && strobe_cnt == resp_delay) begin
        r_ack  = 1'b1;
        r_rdat = resp_data;
      end
      strobe_cnt++;
    end else begin
      strobe_cnt = 0;
    end
    if (spurious) r_ack = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Results of the last run_txn call.
  int          strobes, first_at, ack_at;
  logic        f_wr, f_rd, other_ack, got_err;
  logic [7:0]  f_addr;
  logic [15:0] f_wdat, got_rdat;

  // Issue one request from initiator `who` and follow it to its ack.
  // Loop index i counts falling edges after the request cycle.
  task automatic run_txn(input bit who, input logic wr, input logic rd,
                         input logic [7:0] addr, input logic [15:0] wdat);
    strobes = 0; first_at = -1; ack_at = -1;
    f_wr = 0; f_rd = 0; f_addr = '0; f_wdat = '0;
    other_ack = 0; got_err = 0; got_rdat = '0;
    if (!who) begin
      i0_wr = wr; i0_rd = rd; i0_addr = addr; i0_wdat = wdat;
    end else begin
      i1_wr = wr; i1_rd = rd; i1_addr = addr; i1_wdat = wdat;
    end
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (r_wr || r_rd) begin
        if (first_at < 0) begin
          first_at = i; f_wr = r_wr; f_rd = r_rd; f_addr = r_addr; f_wdat = r_wdat;
        end
        strobes++;
      end
      if (who ? i0_ack : i1_ack) other_ack = 1;
      if (who ? i1_ack : i0_ack) begin
        ack_at   = i;
        got_rdat = who ? i1_rdat : i0_rdat;
        got_err  = who ? i1_err : i0_err;
        break;
      end
    end
    if (!who) begin i0_wr = 0; i0_rd = 0; end
    else      begin i1_wr = 0; i1_rd = 0; end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  int order0, order1, winner;

  initial begin
    // ---------------- reset state
    repeat (2) @(negedge clk);
    check("rst r_wr", r_wr, 0);
    check("rst r_rd", r_rd, 0);
    check("rst r_addr", r_addr, 0);
    check("rst acks", {i0_ack, i1_ack, i0_err, i1_err}, 0);
    check("rst rdat", {i0_rdat, i1_rdat}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // ---------------- 1: i0 write, ack in 4th strobe cycle
    resp_delay = 3; resp_data = 16'h5A5A;
    run_txn(0, 1, 0, 8'h12, 16'hBEEF);
    check("t1 first strobe", first_at, 1);
    check("t1 strobe cycles", strobes, 4);
    check("t1 r_wr/r_rd", {f_wr, f_rd}, 2'b10);
    check("t1 r_addr", f_addr, 8'h12);
    check("t1 r_wdat", f_wdat, 16'hBEEF);
    check("t1 ack cycle", ack_at, 5);
    check("t1 err", got_err, 0);
    check("t1 write rdat", got_rdat, 16'h5A5A);
    check("t1 i1 quiet", other_ack, 0);

    // ---------------- 2: i1 read, immediate ack
    resp_delay = 0; resp_data = 16'h1234;
    run_txn(1, 0, 1, 8'h40, 16'h0000);
    check("t2 r_wr/r_rd", {f_wr, f_rd}, 2'b01);
    check("t2 r_addr", f_addr, 8'h40);
    check("t2 ack cycle", ack_at, 2);
    check("t2 rdat", got_rdat, 16'h1234);
    check("t2 err", got_err, 0);
    check("t2 i0 quiet", other_ack, 0);
    check("t2 i0_rdat held", i0_rdat, 16'h5A5A);

    // ---------------- 3: ties after reset
    do_reset();
    resp_delay = 0;
    for (int rep = 0; rep < 2; rep++) begin
      order0 = -1; order1 = -1;
      i0_wr = 1; i0_addr = 8'h01; i0_wdat = 16'h1111;
      i1_rd = 1; i1_addr = 8'h02;
      for (int i = 1; i <= 40; i++) begin
        @(negedge clk);
        if (i0_ack && order0 < 0) begin order0 = i; i0_wr = 0; end
        if (i1_ack && order1 < 0) begin order1 = i; i1_rd = 0; end
        if (order0 >= 0 && order1 >= 0) break;
      end
      i0_wr = 0; i1_rd = 0;
      check($sformatf("t3 tie%0d i0 ack cycle", rep), order0, 2);
      check($sformatf("t3 tie%0d i1 ack cycle", rep), order1, 5);
      repeat (2) @(negedge clk);
    end
    // Alternation: loser withdraws after the winner's ack; last grant was i1.
    for (int k = 0; k < 8; k++) begin
      winner = -1; order0 = -1;
      i0_wr = 1; i0_addr = 8'h03;
      i1_wr = 1; i1_addr = 8'h04;
      for (int i = 1; i <= 40; i++) begin
        @(negedge clk);
        if (i0_ack || i1_ack) begin
          winner = i1_ack ? 1 : 0;
          if (i0_ack && i1_ack) winner = 2;
          order0 = i;
          break;
        end
      end
      i0_wr = 0; i1_wr = 0;
      check($sformatf("t3 alt%0d winner", k), winner, k % 2);
      check($sformatf("t3 alt%0d ack cycle", k), order0, 2);
      repeat (2) @(negedge clk);
    end

    // ---------------- 4: i0 read timeout
    resp_delay = -1;
    run_txn(0, 0, 1, 8'h33, 16'h0000);
    check("t4 strobe cycles", strobes, 16);
    check("t4 ack cycle", ack_at, 17);
    check("t4 err", got_err, 1);
    check("t4 rdat", got_rdat, 16'hFFFF);
    check("t4 i1 quiet", other_ack, 0);
    check("t4 err cleared", i0_err, 0);

    // ---------------- 5a: ack exactly in the expiry cycle
    resp_delay = 15; resp_data = 16'hC0DE;
    run_txn(1, 0, 1, 8'h55, 16'h0000);
    check("t5 strobe cycles", strobes, 16);
    check("t5 err", got_err, 0);
    check("t5 rdat", got_rdat, 16'hC0DE);
    check("t5 i0_err quiet", i0_err | i1_err, 0);

    // ---------------- 5b: reset in the middle of BUSY
    resp_delay = -1;
    i0_wr = 1; i0_addr = 8'h66; i0_wdat = 16'hAAAA;
    repeat (3) @(negedge clk);
    check("t5 busy r_wr", r_wr, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5 async strobe drop", {r_wr, r_rd}, 0);
    @(negedge clk);
    i0_wr = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("t5 no ack in reset %0d", i), {i0_ack, i1_ack}, 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("t5 no ack after reset %0d", i), {i0_ack, i1_ack}, 0);
    end
    resp_delay = 0; resp_data = 16'h0F0F;
    run_txn(1, 0, 1, 8'h77, 16'h0000);
    check("t5 fresh ack cycle", ack_at, 2);
    check("t5 fresh rdat", got_rdat, 16'h0F0F);
    check("t5 fresh err", got_err, 0);

    // ---------------- 6: spurious ack while idle, wr&rd together
    spurious = 1'b1;
    repeat (3) @(negedge clk);
    spurious = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("t6 spurious %0d", i), {i0_ack, i1_ack, r_wr, r_rd}, 0);
    end
    resp_delay = 1; resp_data = 16'h2222;
    run_txn(1, 1, 1, 8'h88, 16'h9999);
    check("t6 wr&rd strobes", {f_wr, f_rd}, 2'b10);
    check("t6 wdat", f_wdat, 16'h9999);
    check("t6 ack cycle", ack_at, 3);
    check("t6 i0 quiet", other_ack, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
